// File: rtl/axis_pattern_checker.sv
// axis_pattern_checker
// AXI4-Stream sink for the DMA loopback path. Checks an incrementing counter
// pattern (wrapping after WRAP_VAL), optionally auto-syncs to the stream,
// checks tkeep and packet length, captures the first mismatch and reports
// a windowed throughput figure. Every input beat is also forwarded one cycle
// later on o_user_dout for an ILA.
module axis_pattern_checker #(
    parameter int DATA_W      = 64,
    parameter int WRAP_VAL    = 1310720,
    parameter int AUTO_SYNC   = 1,
    parameter int LOCK_LOSS   = 8,
    parameter int PKT_BEATS   = 0,
    parameter int RATE_WINDOW = 200000000,
    parameter int RATE_SHIFT  = 17
) (
    input  logic                  AXI_CLk,
    input  logic                  AXI_RSTN,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  i_clear,
    output logic [DATA_W-1:0]     o_user_dout,
    output logic                  o_user_dout_valid,
    output logic                  o_locked,
    output logic [31:0]           o_err_cnt,
    output logic [31:0]           o_fmt_err_cnt,
    output logic [DATA_W-1:0]     o_first_err_exp,
    output logic [DATA_W-1:0]     o_first_err_got,
    output logic [31:0]           o_beat_cnt,
    output logic [15:0]           o_rate_mb
);

    localparam int KEEP_W   = DATA_W / 8;
    localparam int CONSEC_W = $clog2(LOCK_LOSS + 1);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;
    localparam logic [0:0] ST_RESET    = (AUTO_SYNC != 0) ? ST_UNLOCKED : ST_LOCKED;

    localparam logic [DATA_W-1:0]   WRAP_D    = DATA_W'(WRAP_VAL);
    localparam logic [31:0]         WIN_LAST  = 32'(RATE_WINDOW - 1);
    localparam logic [31:0]         PKT_LEN   = 32'(PKT_BEATS);
    localparam logic [CONSEC_W-1:0] CONSEC_LAST = CONSEC_W'(LOCK_LOSS - 1);

    // Next value of the counter pattern, wrapping after WRAP_VAL.
    function automatic logic [DATA_W-1:0] nxt(input logic [DATA_W-1:0] x);
        return (x == WRAP_D) ? '0 : x + DATA_W'(1);
    endfunction

    // Saturating 32-bit increment for all status counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    logic                rdy;
    logic [DATA_W-1:0]   dout_p1;
    logic                vld_p1;

    logic [0:0]          state;
    logic [DATA_W-1:0]   expected;
    logic [CONSEC_W-1:0] consec;
    logic                captured;
    logic [31:0]         err_cnt;
    logic [31:0]         fmt_cnt;
    logic [DATA_W-1:0]   first_exp;
    logic [DATA_W-1:0]   first_got;
    logic [31:0]         beat_cnt;
    logic [31:0]         beat_idx;

    logic [31:0]         win_cnt;
    logic [31:0]         win_beats;
    logic [15:0]         rate;

    logic                beat;
    logic [31:0]         idx_now;
    logic                keep_bad;
    logic                len_bad;
    logic                fmt_bad;
    logic                data_ok;
    logic [31:0]         win_sum;

    // Per-beat decode: handshake, format violations and data compare.
    always_comb begin
        beat     = s_axis_tvalid & rdy;
        idx_now  = beat_idx + 32'd1;
        keep_bad = (s_axis_tkeep != {KEEP_W{1'b1}});
        len_bad  = 1'b0;
        if (PKT_BEATS > 0) begin
            len_bad = s_axis_tlast ? (idx_now != PKT_LEN) : (idx_now == PKT_LEN);
        end
        fmt_bad  = keep_bad | len_bad;
        data_ok  = (s_axis_tdata == expected);
        win_sum  = win_beats + {31'd0, beat};
    end

    // Hold tready low through reset and the first cycle after it.
    always_ff @(posedge AXI_CLk or negedge AXI_RSTN) begin
        if (!AXI_RSTN) begin
            rdy <= 1'b0;
        end else begin
            rdy <= 1'b1;
        end
    end

    // ---- stage p1: forward every accepted beat, including one in a clear cycle
    always_ff @(posedge AXI_CLk or negedge AXI_RSTN) begin
        if (!AXI_RSTN) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= beat;
            if (beat) begin
                dout_p1 <= s_axis_tdata;
            end
        end
    end

    // Lock FSM, expected-value tracking, error counting and first-error capture.
    always_ff @(posedge AXI_CLk or negedge AXI_RSTN) begin
        if (!AXI_RSTN) begin
            state     <= ST_RESET;
            expected  <= '0;
            consec    <= '0;
            captured  <= 1'b0;
            err_cnt   <= '0;
            fmt_cnt   <= '0;
            first_exp <= '0;
            first_got <= '0;
            beat_cnt  <= '0;
            beat_idx  <= '0;
        end else if (i_clear) begin
            state     <= ST_RESET;
            expected  <= '0;
            consec    <= '0;
            captured  <= 1'b0;
            err_cnt   <= '0;
            fmt_cnt   <= '0;
            first_exp <= '0;
            first_got <= '0;
            beat_cnt  <= '0;
            beat_idx  <= '0;
        end else if (beat) begin
            beat_cnt <= sat_inc(beat_cnt);
            // tkeep and length failures on the same beat count once.
            if (fmt_bad) begin
                fmt_cnt <= sat_inc(fmt_cnt);
            end
            if (PKT_BEATS > 0) begin
                // Restart the packet on tlast or on reaching the nominal length,
                // whether or not that beat was a violation.
                beat_idx <= (s_axis_tlast || (idx_now == PKT_LEN)) ? 32'd0 : idx_now;
            end
            if (state == ST_UNLOCKED) begin
                expected <= nxt(s_axis_tdata);
                consec   <= '0;
                state    <= ST_LOCKED;
            end else if (data_ok) begin
                expected <= nxt(expected);
                consec   <= '0;
            end else begin
                err_cnt <= sat_inc(err_cnt);
                if (!captured) begin
                    captured  <= 1'b1;
                    first_exp <= expected;
                    first_got <= s_axis_tdata;
                end
                if (AUTO_SYNC != 0) begin
                    expected <= nxt(s_axis_tdata);
                    if (consec == CONSEC_LAST) begin
                        consec <= '0;
                        state  <= ST_UNLOCKED;
                    end else begin
                        consec <= consec + CONSEC_W'(1);
                    end
                end else begin
                    expected <= nxt(expected);
                end
            end
        end
    end

    // Throughput window: latch scaled beat count at terminal count, then restart.
    always_ff @(posedge AXI_CLk or negedge AXI_RSTN) begin
        if (!AXI_RSTN) begin
            win_cnt   <= '0;
            win_beats <= '0;
            rate      <= '0;
        end else if (i_clear) begin
            win_cnt   <= '0;
            win_beats <= '0;
            rate      <= '0;
        end else if (win_cnt == WIN_LAST) begin
            rate      <= 16'(win_sum >> RATE_SHIFT);
            win_cnt   <= '0;
            win_beats <= '0;
        end else begin
            win_cnt   <= win_cnt + 32'd1;
            win_beats <= win_sum;
        end
    end

    assign s_axis_tready     = rdy;
    assign o_user_dout       = dout_p1;
    assign o_user_dout_valid = vld_p1;
    assign o_locked          = (state == ST_LOCKED);
    assign o_err_cnt         = err_cnt;
    assign o_fmt_err_cnt     = fmt_cnt;
    assign o_first_err_exp   = first_exp;
    assign o_first_err_got   = first_got;
    assign o_beat_cnt        = beat_cnt;
    assign o_rate_mb         = rate;

endmodule
